// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between a producer and the uart_tx block.
// The block drives the o_* signals and the producer drives the i_* signals.
interface uart_tx_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_txd;
  logic       o_busy;
  logic       o_done;

  modport master (output i_data, output i_valid,
                  input  o_ready, input o_txd, input o_busy, input o_done);
  modport slave  (input  i_data, input i_valid,
                  output o_ready, output o_txd, output o_busy, output o_done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte in the shifter plus a one-entry holding buffer.
// Start bit drives the line 1 edge after accept; o_ready low only while the buffer is full.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      i_clk_tx,
  input  logic      i_reset,
  uart_tx_if.slave  bus
);

  localparam int              DW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      buf_q, buf_d;
  logic            full_q, full_d;
  logic            txd_q, txd_d;
  logic            busy_q;
  logic            done_q, done_d;
  logic            accept;
  logic            div_end;

  assign accept  = bus.i_valid && !full_q;
  assign div_end = (div_q == DIV_LAST);

  assign bus.o_ready = !full_q;
  assign bus.o_txd   = txd_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    buf_d   = buf_q;
    full_d  = full_q;
    done_d  = 1'b0;

    if (accept && state_q != IDLE) begin
      buf_d  = bus.i_data;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = bus.i_data;
          div_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DATA: begin
        if (div_end) begin
          div_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      STOP: begin
        if (div_end) begin
          div_d  = '0;
          done_d = 1'b1;
          if (full_q) begin
            sh_d    = buf_q;
            full_d  = 1'b0;
            state_d = START;
          end else if (accept) begin
            // Byte arriving on the last stop cycle bypasses the buffer.
            sh_d    = bus.i_data;
            full_d  = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk_tx or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      buf_q   <= 8'd0;
      full_q  <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      txd_q   <= txd_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

endmodule
